// File: rtl/sd_ext_dma.sv
// Block-level DMA between the SD manager's 512-byte buffer RAMs and external
// memory over a Wishbone classic master; one block per request, 128 words.
module sd_ext_dma #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] NUM_BLOCKS = 32'd65536,
    parameter logic [7:0]  TIMEOUT    = 8'd255
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic        ext_read_act,
    input  logic [31:0] ext_read_addr,
    input  logic        ext_read_stop,
    output logic        ext_read_go,
    input  logic        ext_write_act,
    input  logic [31:0] ext_write_addr,
    output logic        ext_write_done,
    output logic [6:0]  bram_rd_ext_addr,
    output logic        bram_rd_ext_wren,
    output logic [31:0] bram_rd_ext_data,
    output logic [6:0]  bram_wr_ext_addr,
    input  logic [31:0] bram_wr_ext_q,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy,
    output logic        err,
    input  logic        err_clr
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_BUS   = 3'd1;
    localparam logic [2:0] RD_GO    = 3'd2;
    localparam logic [2:0] RD_REL   = 3'd3;
    localparam logic [2:0] WR_FETCH = 3'd4;
    localparam logic [2:0] WR_BUS   = 3'd5;
    localparam logic [2:0] WR_DONE  = 3'd6;

    logic [2:0]  state;
    logic [22:0] block;
    logic [6:0]  wc;
    logic [7:0]  tcnt;
    logic        rd_hold;
    logic        beat_timeout;
    logic [31:0] word_addr;

    assign word_addr    = BASE_ADDR + {block, 9'b0} + {23'b0, wc, 2'b00};
    assign beat_timeout = (tcnt == TIMEOUT - 8'd1);

    // Bus-side outputs read as zero whenever no cycle is in flight.
    assign wb_adr_o         = wb_cyc_o ? word_addr : 32'h0;
    assign wb_sel_o         = wb_cyc_o ? 4'hF : 4'h0;
    assign wb_dat_o         = wb_we_o ? bram_wr_ext_q : 32'h0;
    assign bram_wr_ext_addr = wc;
    assign busy             = (state != IDLE);

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state            <= IDLE;
            block            <= 23'd0;
            wc               <= 7'd0;
            tcnt             <= 8'd0;
            rd_hold          <= 1'b0;
            err              <= 1'b0;
            ext_read_go      <= 1'b0;
            ext_write_done   <= 1'b0;
            bram_rd_ext_addr <= 7'd0;
            bram_rd_ext_wren <= 1'b0;
            bram_rd_ext_data <= 32'h0;
            wb_we_o          <= 1'b0;
            wb_cyc_o         <= 1'b0;
            wb_stb_o         <= 1'b0;
        end else begin
            bram_rd_ext_wren <= 1'b0;
            // Later error assignments in this block override the clear.
            if (err_clr)
                err <= 1'b0;
            if (!ext_read_act)
                rd_hold <= 1'b0;

            case (state)
                IDLE: begin
                    wc   <= 7'd0;
                    tcnt <= 8'd0;
                    if (ext_read_act && !rd_hold) begin
                        block <= ext_read_addr[22:0];
                        if (ext_read_addr >= NUM_BLOCKS) begin
                            err         <= 1'b1;
                            ext_read_go <= 1'b1;
                            state       <= RD_GO;
                        end else begin
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            state    <= RD_BUS;
                        end
                    end else if (ext_write_act) begin
                        block <= ext_write_addr[22:0];
                        if (ext_write_addr >= NUM_BLOCKS) begin
                            err            <= 1'b1;
                            ext_write_done <= 1'b1;
                            state          <= WR_DONE;
                        end else begin
                            state <= WR_FETCH;
                        end
                    end
                end

                RD_BUS: begin
                    if (wb_stb_o) begin
                        if (wb_err_i || (!wb_ack_i && beat_timeout)) begin
                            err         <= 1'b1;
                            wb_cyc_o    <= 1'b0;
                            wb_stb_o    <= 1'b0;
                            ext_read_go <= 1'b1;
                            state       <= RD_GO;
                        end else if (wb_ack_i) begin
                            bram_rd_ext_wren <= 1'b1;
                            bram_rd_ext_addr <= wc;
                            bram_rd_ext_data <= wb_dat_i;
                            wb_stb_o         <= 1'b0;
                            wc               <= wc + 7'd1;
                            if (wc == 7'd127) begin
                                wb_cyc_o    <= 1'b0;
                                ext_read_go <= 1'b1;
                                state       <= RD_GO;
                            end
                        end else begin
                            tcnt <= tcnt + 8'd1;
                        end
                    end else begin
                        // One idle-strobe cycle while the buffer write lands.
                        wb_stb_o <= 1'b1;
                        tcnt     <= 8'd0;
                    end
                end

                RD_GO: begin
                    if (ext_read_stop) begin
                        ext_read_go <= 1'b0;
                        state       <= RD_REL;
                    end
                end

                RD_REL: begin
                    if (!ext_read_stop) begin
                        rd_hold <= ext_read_act;
                        state   <= IDLE;
                    end
                end

                WR_FETCH: begin
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    wb_we_o  <= 1'b1;
                    tcnt     <= 8'd0;
                    state    <= WR_BUS;
                end

                WR_BUS: begin
                    if (wb_err_i || (!wb_ack_i && beat_timeout)) begin
                        err            <= 1'b1;
                        wb_cyc_o       <= 1'b0;
                        wb_stb_o       <= 1'b0;
                        wb_we_o        <= 1'b0;
                        ext_write_done <= 1'b1;
                        state          <= WR_DONE;
                    end else if (wb_ack_i) begin
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        if (wc == 7'd127) begin
                            wb_cyc_o       <= 1'b0;
                            ext_write_done <= 1'b1;
                            state          <= WR_DONE;
                        end else begin
                            wc    <= wc + 7'd1;
                            state <= WR_FETCH;
                        end
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end

                WR_DONE: begin
                    if (!ext_write_act) begin
                        ext_write_done <= 1'b0;
                        state          <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_ext_dma.sv
// Directed bench for sd_ext_dma: a Wishbone slave and buffer-RAM models feed a
// scoreboard of expected bus beats and read-buffer writes.
module tb_sd_ext_dma;

    logic        clk_50 = 1'b0;
    logic        reset;
    logic        ext_read_act;
    logic [31:0] ext_read_addr;
    logic        ext_read_stop;
    logic        ext_read_go;
    logic        ext_write_act;
    logic [31:0] ext_write_addr;
    logic        ext_write_done;
    logic [6:0]  bram_rd_ext_addr;
    logic        bram_rd_ext_wren;
    logic [31:0] bram_rd_ext_data;
    logic [6:0]  bram_wr_ext_addr;
    logic [31:0] bram_wr_ext_q;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        busy;
    logic        err;
    logic        err_clr;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] exp_bus_adr[$];
    logic [31:0] exp_bus_we[$];
    logic [31:0] exp_bus_dat[$];
    logic [31:0] exp_bram_idx[$];
    logic [31:0] exp_bram_dat[$];

    int ack_delay  = 2;
    int err_beat   = -1;
    bit slave_mute = 1'b0;
    int beat       = 0;
    int wait_cnt   = 0;

    logic [31:0] wmem [0:127];

    sd_ext_dma dut (
        .clk_50           (clk_50),
        .reset            (reset),
        .ext_read_act     (ext_read_act),
        .ext_read_addr    (ext_read_addr),
        .ext_read_stop    (ext_read_stop),
        .ext_read_go      (ext_read_go),
        .ext_write_act    (ext_write_act),
        .ext_write_addr   (ext_write_addr),
        .ext_write_done   (ext_write_done),
        .bram_rd_ext_addr (bram_rd_ext_addr),
        .bram_rd_ext_wren (bram_rd_ext_wren),
        .bram_rd_ext_data (bram_rd_ext_data),
        .bram_wr_ext_addr (bram_wr_ext_addr),
        .bram_wr_ext_q    (bram_wr_ext_q),
        .wb_adr_o         (wb_adr_o),
        .wb_dat_o         (wb_dat_o),
        .wb_dat_i         (wb_dat_i),
        .wb_we_o          (wb_we_o),
        .wb_sel_o         (wb_sel_o),
        .wb_cyc_o         (wb_cyc_o),
        .wb_stb_o         (wb_stb_o),
        .wb_ack_i         (wb_ack_i),
        .wb_err_i         (wb_err_i),
        .busy             (busy),
        .err              (err),
        .err_clr          (err_clr)
    );

    always #5 clk_50 = ~clk_50;

    function automatic logic [31:0] wdata(input int k);
        return 32'hC0DE_0000 + k * 32'h0001_0003;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ra, input logic [31:0] raddr, input logic rstop,
                                 input logic wa, input logic [31:0] waddr, input logic eclr);
        ext_read_act   = ra;
        ext_read_addr  = raddr;
        ext_read_stop  = rstop;
        ext_write_act  = wa;
        ext_write_addr = waddr;
        err_clr        = eclr;
    endtask

    task automatic expectRead(input int blk, input int nwords);
        logic [31:0] a;
        for (int k = 0; k < nwords; k++) begin
            a = blk * 512 + k * 4;
            exp_bus_adr.push_back(a);
            exp_bus_we.push_back(32'd0);
            exp_bus_dat.push_back(32'd0);
            exp_bram_idx.push_back(k);
            exp_bram_dat.push_back(a ^ 32'h5A5A_0000);
        end
    endtask

    task automatic expectWrite(input int blk, input int nwords);
        for (int k = 0; k < nwords; k++) begin
            exp_bus_adr.push_back(blk * 512 + k * 4);
            exp_bus_we.push_back(32'd1);
            exp_bus_dat.push_back(wdata(k));
        end
    endtask

    // which: 0 read go, 1 write done, 3 cyc raised
    task automatic waitFor(input int which, input int budget, input string tag);
        int  n;
        bit  hit;
        n   = 0;
        hit = 1'b0;
        while (n < budget && !hit) begin
            @(negedge clk_50);
            n++;
            case (which)
                0:       hit = ext_read_go;
                1:       hit = ext_write_done;
                default: hit = wb_cyc_o;
            endcase
        end
        checkOutput(tag, {31'd0, hit}, 32'd1);
    endtask

    task automatic checkQueuesEmpty(input string tag);
        checkOutput({tag, "_busq"}, exp_bus_adr.size(), 0);
        checkOutput({tag, "_bramq"}, exp_bram_idx.size(), 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 0);
        checkOutput({tag, "_err"}, {31'd0, err}, 0);
        checkOutput({tag, "_go"}, {31'd0, ext_read_go}, 0);
        checkOutput({tag, "_done"}, {31'd0, ext_write_done}, 0);
        checkOutput({tag, "_cycstbwe"}, {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 0);
        checkOutput({tag, "_wren"}, {31'd0, bram_rd_ext_wren}, 0);
        checkOutput({tag, "_adr"}, wb_adr_o, 0);
        checkOutput({tag, "_sel"}, {28'd0, wb_sel_o}, 0);
        checkOutput({tag, "_dato"}, wb_dat_o, 0);
        checkOutput({tag, "_wraddr"}, {25'd0, bram_wr_ext_addr}, 0);
    endtask

    always @(posedge clk_50)
        bram_wr_ext_q <= wmem[bram_wr_ext_addr];

    // Wishbone slave: acks on the ack_delay-th strobe cycle, checks each beat.
    always @(negedge clk_50) begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        if (wb_cyc_o && wb_stb_o && !slave_mute) begin
            wait_cnt++;
            if (wait_cnt >= ack_delay) begin
                wait_cnt = 0;
                if (beat == err_beat) begin
                    wb_err_i = 1'b1;
                end else begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = wb_adr_o ^ 32'h5A5A_0000;
                    if (exp_bus_adr.size() == 0) begin
                        checkOutput("bus_unexpected", 32'd1, 32'd0);
                    end else begin
                        logic [31:0] ew;
                        logic [31:0] ed;
                        ew = exp_bus_we.pop_front();
                        ed = exp_bus_dat.pop_front();
                        checkOutput("bus_adr", wb_adr_o, exp_bus_adr.pop_front());
                        checkOutput("bus_we", {31'd0, wb_we_o}, ew);
                        checkOutput("bus_sel", {28'd0, wb_sel_o}, 32'hF);
                        if (ew == 32'd1)
                            checkOutput("bus_dat", wb_dat_o, ed);
                    end
                end
                beat++;
            end
        end
    end

    always @(negedge clk_50) begin
        if (bram_rd_ext_wren) begin
            if (exp_bram_idx.size() == 0) begin
                checkOutput("bram_unexpected", 32'd1, 32'd0);
            end else begin
                checkOutput("bram_idx", {25'd0, bram_rd_ext_addr}, exp_bram_idx.pop_front());
                checkOutput("bram_dat", bram_rd_ext_data, exp_bram_dat.pop_front());
            end
        end
    end

    initial begin
        int n;
        for (int k = 0; k < 128; k++)
            wmem[k] = wdata(k);
        wb_dat_i = 32'h0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk_50);
        checkAllZero("reset");
        reset = 1'b0;
        @(negedge clk_50);

        // Read block 3, level held through the handshake.
        beat = 0;
        expectRead(3, 128);
        applyStimulus(1, 3, 0, 0, 0, 0);
        waitFor(0, 1000, "rd3_go");
        checkOutput("rd3_cyc_low", {31'd0, wb_cyc_o}, 0);
        checkOutput("rd3_err", {31'd0, err}, 0);
        repeat (3) @(negedge clk_50);
        checkQueuesEmpty("rd3");
        checkOutput("rd3_go_held", {31'd0, ext_read_go}, 1);
        applyStimulus(1, 3, 1, 0, 0, 0);
        @(negedge clk_50);
        checkOutput("rd3_go_released", {31'd0, ext_read_go}, 0);
        checkOutput("rd3_rel_busy", {31'd0, busy}, 1);
        applyStimulus(1, 3, 0, 0, 0, 0);
        @(negedge clk_50);
        checkOutput("rd3_idle", {31'd0, busy}, 0);
        repeat (4) @(negedge clk_50);
        checkOutput("rd3_no_restart", {30'd0, busy, wb_cyc_o}, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk_50);

        // Write block 1.
        beat = 0;
        expectWrite(1, 128);
        applyStimulus(0, 0, 0, 1, 1, 0);
        waitFor(1, 1500, "wr1_done");
        repeat (2) @(negedge clk_50);
        checkQueuesEmpty("wr1");
        checkOutput("wr1_done_held", {31'd0, ext_write_done}, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk_50);
        checkOutput("wr1_done_low", {31'd0, ext_write_done}, 0);
        checkOutput("wr1_idle", {31'd0, busy}, 0);

        // Read 7 and write 2 requested together: read goes first.
        beat = 0;
        expectRead(7, 128);
        expectWrite(2, 128);
        applyStimulus(1, 7, 0, 1, 2, 0);
        waitFor(0, 1000, "both_rd_go");
        applyStimulus(0, 0, 1, 1, 2, 0);
        @(negedge clk_50);
        applyStimulus(0, 0, 0, 1, 2, 0);
        waitFor(1, 1500, "both_wr_done");
        @(negedge clk_50);
        checkQueuesEmpty("both");
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk_50);
        checkOutput("both_idle", {31'd0, busy}, 0);

        // Bus error on beat 5 of a read.
        beat     = 0;
        err_beat = 5;
        expectRead(4, 5);
        applyStimulus(1, 4, 0, 0, 0, 0);
        waitFor(0, 200, "berr_go");
        checkOutput("berr_err", {31'd0, err}, 1);
        checkOutput("berr_cyc", {31'd0, wb_cyc_o}, 0);
        @(negedge clk_50);
        checkQueuesEmpty("berr");
        applyStimulus(0, 0, 0, 0, 0, 1);
        @(negedge clk_50);
        checkOutput("berr_cleared", {31'd0, err}, 0);
        checkOutput("berr_go_held", {31'd0, ext_read_go}, 1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        @(negedge clk_50);
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk_50);
        err_beat = -1;

        // Silent slave: beat times out after TIMEOUT strobe cycles.
        slave_mute = 1'b1;
        applyStimulus(1, 2, 0, 0, 0, 0);
        waitFor(3, 10, "to_cyc_up");
        n = 0;
        while (wb_cyc_o && n < 400) begin
            n++;
            @(negedge clk_50);
        end
        checkOutput("to_cyc_cycles", n, 255);
        checkOutput("to_err", {31'd0, err}, 1);
        checkOutput("to_go", {31'd0, ext_read_go}, 1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        @(negedge clk_50);
        applyStimulus(0, 0, 0, 0, 0, 1);
        @(negedge clk_50);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk_50);
        checkOutput("to_cleared", {31'd0, err}, 0);
        slave_mute = 1'b0;
        wait_cnt   = 0;

        // Out-of-range block, with err_clr in the same cycle the error is raised.
        applyStimulus(1, 65536, 0, 0, 0, 1);
        @(negedge clk_50);
        applyStimulus(1, 65536, 0, 0, 0, 0);
        checkOutput("inv_err_wins", {31'd0, err}, 1);
        checkOutput("inv_go", {31'd0, ext_read_go}, 1);
        checkOutput("inv_no_cyc", {31'd0, wb_cyc_o}, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        @(negedge clk_50);
        applyStimulus(0, 0, 0, 0, 0, 1);
        @(negedge clk_50);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk_50);

        // Reset during beat 60 of a write.
        beat = 0;
        expectWrite(5, 60);
        applyStimulus(0, 0, 0, 1, 5, 0);
        n = 0;
        while (beat < 60 && n < 1000) begin
            @(posedge clk_50);
            n++;
        end
        checkOutput("rst_beat60", beat, 60);
        #1;
        reset         = 1'b1;
        ext_write_act = 1'b0;
        @(posedge clk_50);
        #1;
        checkAllZero("rst_mid");
        @(negedge clk_50);
        reset = 1'b0;
        checkQueuesEmpty("rst_mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
